// File: rtl/rf_port_sched.sv
// rf_port_sched: arbitrates two write requesters (ALU, load) and one read
// requester onto a 2R/1W register-file port set. Writes beat reads, A/B
// round-robin, with a starvation counter that forces a read after four
// write grants issued while a read was waiting.
// Optional macro RF_ZERO_GUARD_EN: writes to r0 are granted but not issued.
module rf_port_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wa_req,
  input  logic [4:0]  wa_addr,
  input  logic [31:0] wa_data,
  output logic        wa_gnt,
  input  logic        wb_req,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_gnt,
  input  logic        rd_req,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        rd_gnt,
  output logic        rd_valid,
  output logic [4:0]  rf_r1_addr,
  output logic [4:0]  rf_r2_addr,
  output logic [4:0]  rf_r3_addr,
  output logic [31:0] rf_r3_in,
  output logic        rf_r3_we
);

  logic        last_b_q, last_b_d;     // 1: last write winner was B
  logic [2:0]  cnt_q, cnt_d;           // write grants while a read waits
  logic [1:0]  vld_pipe_q, vld_pipe_d; // read grant -> rd_valid delay line
  logic [4:0]  r1_addr_q, r1_addr_d;
  logic [4:0]  r2_addr_q, r2_addr_d;
  logic [4:0]  r3_addr_q, r3_addr_d;
  logic [31:0] r3_in_q, r3_in_d;
  logic        r3_we_q, r3_we_d;

  logic        force_rd;
  logic        wr_gnt;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_zero;

  // Grant selection: forced read, then writes (round-robin), then read.
  // Grants are gated by rst_n so nothing is granted while in reset.
  always_comb begin
    wa_gnt   = 1'b0;
    wb_gnt   = 1'b0;
    rd_gnt   = 1'b0;
    force_rd = rd_req & cnt_q[2];
    if (rst_n) begin
      if (force_rd)              rd_gnt = 1'b1;
      else if (wa_req && wb_req) begin
        if (last_b_q) wa_gnt = 1'b1;
        else          wb_gnt = 1'b1;
      end
      else if (wa_req)           wa_gnt = 1'b1;
      else if (wb_req)           wb_gnt = 1'b1;
      else if (rd_req)           rd_gnt = 1'b1;
    end
  end

  // Next-state for pointer, starvation counter and port registers.
  always_comb begin
    wr_gnt  = wa_gnt | wb_gnt;
    wr_addr = wa_gnt ? wa_addr : wb_addr;
    wr_data = wa_gnt ? wa_data : wb_data;
`ifdef RF_ZERO_GUARD_EN
    wr_zero = (wr_addr == 5'd0);
`else
    wr_zero = 1'b0;
`endif
    last_b_d = wr_gnt ? wb_gnt : last_b_q;

    cnt_d = cnt_q;
    if (!rd_req || rd_gnt) cnt_d = 3'd0;
    else if (wr_gnt)       cnt_d = cnt_q + 3'd1;

    r3_addr_d  = wr_gnt ? wr_addr : r3_addr_q;
    r3_in_d    = wr_gnt ? wr_data : r3_in_q;
    r3_we_d    = wr_gnt & ~wr_zero;
    r1_addr_d  = rd_gnt ? rd_a1 : r1_addr_q;
    r2_addr_d  = rd_gnt ? rd_a2 : r2_addr_q;
    vld_pipe_d = {vld_pipe_q[0], rd_gnt};
  end

  // State registers; async reset drops any pending write / read-valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q   <= 1'b1;
      cnt_q      <= 3'd0;
      vld_pipe_q <= 2'b00;
      r1_addr_q  <= 5'd0;
      r2_addr_q  <= 5'd0;
      r3_addr_q  <= 5'd0;
      r3_in_q    <= 32'd0;
      r3_we_q    <= 1'b0;
    end else begin
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      r1_addr_q  <= r1_addr_d;
      r2_addr_q  <= r2_addr_d;
      r3_addr_q  <= r3_addr_d;
      r3_in_q    <= r3_in_d;
      r3_we_q    <= r3_we_d;
    end
  end

  assign rd_valid   = vld_pipe_q[1];
  assign rf_r1_addr = r1_addr_q;
  assign rf_r2_addr = r2_addr_q;
  assign rf_r3_addr = r3_addr_q;
  assign rf_r3_in   = r3_in_q;
  assign rf_r3_we   = r3_we_q;

endmodule

// File: tb/tb_rf_port_sched.sv
// Directed bench for rf_port_sched. Inputs change 1ns after the rising
// edge; grants are sampled 1ns later, registered outputs 1ns after the edge.
module tb_rf_port_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wa_req = 1'b0, wb_req = 1'b0, rd_req = 1'b0;
  logic [4:0]  wa_addr = '0, wb_addr = '0, rd_a1 = '0, rd_a2 = '0;
  logic [31:0] wa_data = '0, wb_data = '0;
  logic        wa_gnt, wb_gnt, rd_gnt, rd_valid, rf_r3_we;
  logic [4:0]  rf_r1_addr, rf_r2_addr, rf_r3_addr;
  logic [31:0] rf_r3_in;
  int          passed = 0;
  int          total  = 0;

  rf_port_sched dut (
    .clk(clk), .rst_n(rst_n),
    .wa_req(wa_req), .wa_addr(wa_addr), .wa_data(wa_data), .wa_gnt(wa_gnt),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .rd_req(rd_req), .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
    .rf_r3_addr(rf_r3_addr), .rf_r3_in(rf_r3_in), .rf_r3_we(rf_r3_we)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_reqs();
    wa_req = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_reqs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wa_req = 1'b1; wb_req = 1'b1; rd_req = 1'b1;
    tick(); #1;
    total++;
    if ({wa_gnt, wb_gnt, rd_gnt} !== 3'b000)
      $display("FAIL reset_grants: got %b exp 000", {wa_gnt, wb_gnt, rd_gnt});
    else passed++;
    total++;
    if ({rd_valid, rf_r3_we, rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_in} !== 49'd0)
      $display("FAIL reset_outputs: got we=%b v=%b r1=%0d r2=%0d r3=%0d in=%h exp all 0",
               rf_r3_we, rd_valid, rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_in);
    else passed++;
    clear_reqs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    wa_req = 1'b1; wa_addr = 5'd5; wa_data = 32'h1234;
    #1;
    total++;
    if ({wa_gnt, wb_gnt, rd_gnt} !== 3'b100)
      $display("FAIL wr_gnt: got %b exp 100", {wa_gnt, wb_gnt, rd_gnt});
    else passed++;
    tick();
    wa_req = 1'b0;
    total++;
    if ({rf_r3_we, rf_r3_addr, rf_r3_in} !== {1'b1, 5'd5, 32'h1234})
      $display("FAIL wr_issue: got we=%b a=%0d d=%h exp we=1 a=5 d=1234",
               rf_r3_we, rf_r3_addr, rf_r3_in);
    else passed++;
    tick();
    total++;
    if ({rf_r3_we, rf_r3_addr, rf_r3_in} !== {1'b0, 5'd5, 32'h1234})
      $display("FAIL wr_idle_hold: got we=%b a=%0d d=%h exp we=0 a=5 d=1234",
               rf_r3_we, rf_r3_addr, rf_r3_in);
    else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    wa_req = 1'b1; wa_addr = 5'd1; wa_data = 32'hA;
    wb_req = 1'b1; wb_addr = 5'd2; wb_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({wa_gnt, wb_gnt, rd_gnt} !== ((i % 2 == 0) ? 3'b100 : 3'b010))
        $display("FAIL rr_gnt%0d: got %b exp %b", i, {wa_gnt, wb_gnt, rd_gnt},
                 (i % 2 == 0) ? 3'b100 : 3'b010);
      else passed++;
      tick();
      total++;
      if (rf_r3_addr !== ((i % 2 == 0) ? 5'd1 : 5'd2))
        $display("FAIL rr_addr%0d: got %0d exp %0d", i, rf_r3_addr, (i % 2 == 0) ? 1 : 2);
      else passed++;
    end
    clear_reqs();
  endtask

  task automatic test_starvation();
    do_reset();
    wa_req = 1'b1; wa_addr = 5'd3; wa_data = 32'h33;
    wb_req = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    rd_req = 1'b1; rd_a1 = 5'd9; rd_a2 = 5'd10;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({wa_gnt, wb_gnt, rd_gnt} !== ((i == 4) ? 3'b001 : (i % 2 == 0) ? 3'b100 : 3'b010))
        $display("FAIL starve_gnt%0d: got %b", i, {wa_gnt, wb_gnt, rd_gnt});
      else passed++;
      tick();
    end
    clear_reqs();
    total++;
    if ({rf_r3_we, rf_r1_addr, rf_r2_addr, rd_valid} !== {1'b0, 5'd9, 5'd10, 1'b0})
      $display("FAIL starve_rd_addr: got we=%b r1=%0d r2=%0d v=%b exp we=0 r1=9 r2=10 v=0",
               rf_r3_we, rf_r1_addr, rf_r2_addr, rd_valid);
    else passed++;
    tick();
    total++;
    if (rd_valid !== 1'b1) $display("FAIL starve_valid: got %b exp 1", rd_valid);
    else passed++;
    tick();
    total++;
    if (rd_valid !== 1'b0) $display("FAIL starve_valid_end: got %b exp 0", rd_valid);
    else passed++;
  endtask

  task automatic test_write_read();
    do_reset();
    wa_req = 1'b1; wa_addr = 5'd7; wa_data = 32'hCAFE;
    tick();
    wa_req = 1'b0;
    rd_req = 1'b1; rd_a1 = 5'd7; rd_a2 = 5'd0;
    #1;
    total++;
    if ({rd_gnt, rf_r3_we} !== 2'b11)
      $display("FAIL wrrd_gnt: got rd_gnt=%b we=%b exp 1 1", rd_gnt, rf_r3_we);
    else passed++;
    tick();
    rd_req = 1'b0;
    total++;
    if ({rf_r1_addr, rf_r2_addr, rf_r3_we, rd_valid} !== {5'd7, 5'd0, 1'b0, 1'b0})
      $display("FAIL wrrd_addr: got r1=%0d r2=%0d we=%b v=%b exp 7 0 0 0",
               rf_r1_addr, rf_r2_addr, rf_r3_we, rd_valid);
    else passed++;
    tick();
    total++;
    if ({rd_valid, rf_r3_addr, rf_r3_in} !== {1'b1, 5'd7, 32'hCAFE})
      $display("FAIL wrrd_valid: got v=%b a=%0d d=%h exp 1 7 cafe", rd_valid, rf_r3_addr, rf_r3_in);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rd_a1 = 5'(i + 1); rd_a2 = 5'(i + 11);
      if (i >= 3) rd_req = 1'b0;
      tick();
      // grants at cycles 0..2 with a1 = 1,2,3; valid on cycles 2..4 (samples i = 1..3)
      total++;
      if (rd_valid !== ((i >= 1 && i <= 3) ? 1'b1 : 1'b0))
        $display("FAIL b2b_valid%0d: got %b", i, rd_valid);
      else passed++;
      if (i < 3) begin
        total++;
        if (rf_r1_addr !== 5'(i + 1))
          $display("FAIL b2b_addr%0d: got %0d exp %0d", i, rf_r1_addr, i + 1);
        else passed++;
      end
    end
  endtask

  task automatic test_zero_guard();
    do_reset();
    wb_req = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    #1;
    total++;
    if (wb_gnt !== 1'b1) $display("FAIL zero_gnt: got %b exp 1", wb_gnt);
    else passed++;
    tick();
    wb_req = 1'b0;
    total++;
`ifdef RF_ZERO_GUARD_EN
    if (rf_r3_we !== 1'b0) $display("FAIL zero_we: got %b exp 0", rf_r3_we);
`else
    if (rf_r3_we !== 1'b1) $display("FAIL zero_we: got %b exp 1", rf_r3_we);
`endif
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wa_req = 1'b1; wa_addr = 5'd12; wa_data = 32'hDEAD;
    tick();
    wa_req = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rf_r3_we, rf_r3_addr, rf_r3_in} !== 38'd0)
      $display("FAIL mid_rst_wr: got we=%b a=%0d d=%h exp all 0", rf_r3_we, rf_r3_addr, rf_r3_in);
    else passed++;
    tick();
    rst_n = 1'b1;
    rd_req = 1'b1; rd_a1 = 5'd3;
    tick();
    rd_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({rd_valid, rf_r3_we} !== 2'b00)
      $display("FAIL mid_rst_rd: got v=%b we=%b exp 0 0", rd_valid, rf_r3_we);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_starvation();
    test_write_read();
    test_back_to_back();
    test_zero_guard();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1);
  end
endmodule
